// File: rtl/v_in_pio_pkg.sv
// -----------------------------------------------------------------------------
// v_in_pio_pkg
// Purpose : shared constants for the v_in_pio_capture parallel-input block:
//           Avalon-MM word addresses of the register map and the width and
//           ceiling of the saturating change counter.
// Ports   : none (package).
// -----------------------------------------------------------------------------
package v_in_pio_pkg;

   localparam logic [2:0] ADDR_DATA0 = 3'd0;   // channel c lives at ADDR_DATA0 + c
   localparam logic [2:0] ADDR_EDGE  = 3'd4;
   localparam logic [2:0] ADDR_MASK  = 3'd5;
   localparam logic [2:0] ADDR_COUNT = 3'd6;

   localparam int                 COUNT_W   = 16;
   localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

endpackage

// File: rtl/v_in_pio_sync2.sv
// -----------------------------------------------------------------------------
// v_in_pio_sync2
// Purpose : two-flop synchronizer for a vector of unrelated asynchronous bits.
// Ports   : clk      - destination clock
//           reset_n  - asynchronous active-low reset, clears both stages
//           i_async  - asynchronous input vector
//           o_sync   - synchronized output (second flop)
// -----------------------------------------------------------------------------
module v_in_pio_sync2 #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] i_async,
   output logic [WIDTH-1:0] o_sync
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
      end
   end

   assign o_sync = r_sync;

endmodule

// File: rtl/v_in_pio_capture.sv
// -----------------------------------------------------------------------------
// v_in_pio_capture
// Purpose : Avalon-MM readable parallel input port with N_CH channels of
//           DATA_W bits. Inputs are synchronized, readable at addresses 0..3,
//           and (optionally) tracked for change events with a W1C edge
//           register, interrupt mask, saturating change counter and level irq.
// Build   : define V_IN_PIO_CAPTURE_IRQ_EN to include edge_capture, irq_mask,
//           change_count and irq. Without it addresses 4..6 read 0 and irq
//           is tied low.
// Ports   : clk, reset_n (async active-low)
//           address[2:0], chipselect, write, writedata[31:0] - slave write side
//           in_port[N_CH*DATA_W-1:0] - async inputs, channel c at c*DATA_W
//           readdata[31:0] - registered read data, 1-cycle latency, no strobe
//           irq            - registered level interrupt
// -----------------------------------------------------------------------------
module v_in_pio_capture
   import v_in_pio_pkg::*;
#(
   parameter int DATA_W = 9,
   parameter int N_CH   = 2
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [2:0]             address,
   input  logic                   chipselect,
   input  logic                   write,
   input  logic [31:0]            writedata,
   input  logic [N_CH*DATA_W-1:0] in_port,
   output logic [31:0]            readdata,
   output logic                   irq
);

   localparam int IN_W = N_CH * DATA_W;

   logic [IN_W-1:0] w_sync;
   logic [31:0]     w_rdata;
   logic [31:0]     r_readdata;
   logic            w_wr;

   assign w_wr = chipselect & write;

   v_in_pio_sync2 #(
      .WIDTH (IN_W)
   ) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .i_async (in_port),
      .o_sync  (w_sync)
   );

`ifdef V_IN_PIO_CAPTURE_IRQ_EN
   logic [IN_W-1:0]    r_prev;
   logic [N_CH-1:0]    w_event;
   logic [N_CH-1:0]    r_edge;
   logic [N_CH-1:0]    r_mask;
   logic [COUNT_W-1:0] r_count;
   logic               r_irq;

   always_comb begin
      w_event = '0;
      for (int c = 0; c < N_CH; c++) begin
         w_event[c] = |(w_sync[c*DATA_W +: DATA_W] ^ r_prev[c*DATA_W +: DATA_W]);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_prev  <= '0;
         r_edge  <= '0;
         r_mask  <= '0;
         r_count <= '0;
         r_irq   <= 1'b0;
      end else begin
         r_prev <= w_sync;

         // OR-ing the new events in after the W1C clear lets a same-cycle set win
         if (w_wr && (address == ADDR_EDGE))
            r_edge <= (r_edge & ~writedata[N_CH-1:0]) | w_event;
         else
            r_edge <= r_edge | w_event;

         if (w_wr && (address == ADDR_MASK))
            r_mask <= writedata[N_CH-1:0];

         // any write clears, and the clear beats a coincident event
         if (w_wr && (address == ADDR_COUNT))
            r_count <= '0;
         else if ((|w_event) && (r_count != COUNT_MAX))
            r_count <= r_count + COUNT_W'(1);

         r_irq <= |(r_edge & r_mask);
      end
   end

   assign irq = r_irq;
`else
   assign irq = 1'b0;
`endif

   always_comb begin
      w_rdata = '0;
      for (int c = 0; c < N_CH; c++) begin
         if (address == (ADDR_DATA0 + 3'(c)))
            w_rdata = 32'(w_sync[c*DATA_W +: DATA_W]);
      end
`ifdef V_IN_PIO_CAPTURE_IRQ_EN
      case (address)
         ADDR_EDGE:  w_rdata = 32'(r_edge);
         ADDR_MASK:  w_rdata = 32'(r_mask);
         ADDR_COUNT: w_rdata = 32'(r_count);
         default:    ;
      endcase
`endif
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_readdata <= '0;
      else
         r_readdata <= w_rdata;
   end

   assign readdata = r_readdata;

   // upper writedata bits (and, without the irq feature, the whole write side) are don't-care
   logic w_unused_ok;
   assign w_unused_ok = &{1'b0, w_wr, writedata};

endmodule
